// File: rtl/slp_seq_infer_pkg.sv
// Shared types and helpers for the perceptron layer engines: number-format
// descriptors, activation selection, the sequential engine's state encoding
// and the output range limits used by the saturating requantiser.
package slp_seq_infer_pkg;

  // Numeric representation of a data stream.
  typedef enum logic [1:0] {
    INT = 2'd0,
    FXP = 2'd1,
    FLP = 2'd2
  } dtype_t;

  // Data format: representation, signedness, total bits, fraction bits.
  typedef struct packed {
    dtype_t     dtype;
    logic       sign;
    logic [7:0] prec;
    logic [7:0] frac;
  } dconf_t;

  // Activation function; anything other than RELU passes values through.
  typedef enum logic [1:0] {
    IDENT = 2'd0,
    RELU  = 2'd1
  } actf_t;

  // Sequential layer engine states.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_ACT   = 3'd3,
    S_EMIT  = 3'd4
  } slp_seq_state_t;

  // Largest value representable in format c.
  function automatic longint conf_max(dconf_t c);
    int p;
    p = int'(c.prec);
    return c.sign ? (64'sd1 <<< (p - 1)) - 64'sd1 : (64'sd1 <<< p) - 64'sd1;
  endfunction

  // Smallest value representable in format c (0 for unsigned formats).
  function automatic longint conf_min(dconf_t c);
    int p;
    p = int'(c.prec);
    return c.sign ? -(64'sd1 <<< (p - 1)) : 64'sd0;
  endfunction

endpackage

// File: rtl/slp_seq_infer_requant.sv
// Combinational activation + requantisation: applies the activation, aligns
// the accumulator's fraction to the output format (floor on right shifts),
// reports discarded fraction bits and saturates to the output range.
module slp_requant
  import slp_seq_infer_pkg::*;
#(
  parameter int     ACC_W   = 20,
  parameter int     FRAC_IN = 0,
  parameter dconf_t O_CONF  = '{INT, 1'b1, 8'd8, 8'd0},
  parameter actf_t  ACT     = RELU,
  localparam int    O_PREC  = int'(O_CONF.prec)
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic        [O_PREC-1:0] q,
  output logic                     udf,
  output logic                     ovf,
  output logic                     rounded
);

  localparam int S   = FRAC_IN - int'(O_CONF.frac);
  localparam int RSH = (S > 0) ? S : 0;
  localparam int LSH = (S < 0) ? -S : 0;
  // Wide enough for a left-shifted accumulator and for the output limits.
  localparam int WW  = (((ACC_W + LSH) > O_PREC) ? (ACC_W + LSH) : O_PREC) + 1;

  localparam logic signed [WW-1:0] OMAX_W = WW'(conf_max(O_CONF));
  localparam logic signed [WW-1:0] OMIN_W = WW'(conf_min(O_CONF));
  localparam logic        [WW-1:0] RMASK  = (WW'(1) << RSH) - WW'(1);

  logic signed [ACC_W-1:0] act_v;
  logic signed [WW-1:0]    wide;
  logic signed [WW-1:0]    shifted;

  // Activation, fraction alignment, round-flag and saturation.
  always_comb begin
    // NOTE: every output gets a default first so no path through this block leaves a value unassigned (no latch).
    act_v   = acc;
    q       = '0;
    udf     = 1'b0;
    ovf     = 1'b0;
    if (ACT == RELU && acc[ACC_W-1]) act_v = '0;
    wide    = {{(WW-ACC_W){act_v[ACC_W-1]}}, act_v};
    rounded = |(wide & RMASK);
    shifted = (wide >>> RSH) <<< LSH;
    if (shifted > OMAX_W) begin
      ovf = 1'b1;
      q   = OMAX_W[O_PREC-1:0];
    end else if (shifted < OMIN_W) begin
      udf = 1'b1;
      q   = OMIN_W[O_PREC-1:0];
    end else begin
      q   = shifted[O_PREC-1:0];
    end
  end

endmodule

// File: rtl/slp_seq_infer.sv
// Sequential single-layer perceptron engine. One input vector per
// transaction; each neuron is evaluated by a single time-multiplexed MAC over
// IN weights plus a bias read from an external 1-cycle-latency weight memory.
// Results stream out one neuron at a time under valid/ready flow control.
module slp_seq_infer
  import slp_seq_infer_pkg::*;
#(
  parameter int     IN     = 4,
  parameter int     OUT    = 2,
  parameter dconf_t I_CONF = '{INT, 1'b1, 8'd8, 8'd0},
  parameter dconf_t W_CONF = '{INT, 1'b1, 8'd8, 8'd0},
  parameter dconf_t O_CONF = '{INT, 1'b1, 8'd8, 8'd0},
  parameter actf_t  ACT    = RELU,
  localparam int    I_PREC = int'(I_CONF.prec),
  localparam int    W_PREC = int'(W_CONF.prec),
  localparam int    O_PREC = int'(O_CONF.prec),
  localparam int    I_FRAC = int'(I_CONF.frac),
  localparam int    W_FRAC = int'(W_CONF.frac),
  localparam int    ACC_W  = I_PREC + W_PREC + $clog2(IN + 1) + 1,
  localparam int    WA_W   = $clog2(OUT * (IN + 1)),
  localparam int    NW     = $clog2(OUT) + 1,
  localparam int    KW     = $clog2(IN + 1)
) (
  input  logic                 clk,
  input  logic                 reset_,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN*I_PREC-1:0] in_data,
  output logic                 w_rd_en,
  output logic [WA_W-1:0]      w_addr,
  input  logic [W_PREC-1:0]    w_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NW-1:0]        out_idx,
  output logic                 out_last,
  output logic [O_PREC-1:0]    out,
  output logic                 udf,
  output logic                 ovf,
  output logic                 rounded
);

  localparam bit I_SIGN = I_CONF.sign;
  localparam bit W_SIGN = W_CONF.sign;

  slp_seq_state_t          state;
  logic [IN*I_PREC-1:0]    in_reg;
  logic [NW-1:0]           n;
  logic [KW-1:0]           k;
  logic [KW-1:0]           rd_k;
  logic                    rd_vld;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] term;
  logic [I_PREC-1:0]       x_el;
  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] w_ext;
  logic                    last_nrn;
  logic [O_PREC-1:0]       rq_q;
  logic                    rq_udf;
  logic                    rq_ovf;
  logic                    rq_rnd;

  // Handshake/strobe outputs decode directly from the state register.
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_EMIT);
  assign w_rd_en   = (state == S_FETCH);
  assign last_nrn  = (n == NW'(OUT - 1));

  // Contribution of the word returned this cycle: input*weight, or the bias
  // aligned to the product's fraction position.
  always_comb begin
    x_el = '0;
    if (rd_k < KW'(IN)) x_el = in_reg[int'(rd_k)*I_PREC +: I_PREC];
    x_ext = {{(ACC_W-I_PREC){I_SIGN & x_el[I_PREC-1]}}, x_el};
    w_ext = {{(ACC_W-W_PREC){W_SIGN & w_rdata[W_PREC-1]}}, w_rdata};
    term  = (rd_k == KW'(IN)) ? (w_ext <<< I_FRAC) : (x_ext * w_ext);
  end

  // MAC: track the outstanding read and accumulate its data a cycle later.
  always_ff @(posedge clk or negedge reset_) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (!reset_) begin
      rd_vld <= 1'b0;
      rd_k   <= '0;
      acc    <= '0;
    end else begin
      rd_vld <= w_rd_en;
      rd_k   <= k;
      if ((in_valid && in_ready) || (out_valid && out_ready)) acc <= '0;
      else if (rd_vld)                                        acc <= acc + term;
    end
  end

  slp_requant #(
    .ACC_W   (ACC_W),
    .FRAC_IN (I_FRAC + W_FRAC),
    .O_CONF  (O_CONF),
    .ACT     (ACT)
  ) u_requant (
    .acc     (acc),
    .q       (rq_q),
    .udf     (rq_udf),
    .ovf     (rq_ovf),
    .rounded (rq_rnd)
  );

  // Control FSM: capture, fetch IN weights + bias, drain, requantise, emit.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state    <= S_IDLE;
      // NOTE: the captured vector is a plain register bank, so it is cleared with the control state.
      in_reg   <= '0;
      n        <= '0;
      k        <= '0;
      w_addr   <= '0;
      out      <= '0;
      udf      <= 1'b0;
      ovf      <= 1'b0;
      rounded  <= 1'b0;
      out_idx  <= '0;
      out_last <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            in_reg <= in_data;
            n      <= '0;
            k      <= '0;
            w_addr <= '0;
            state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          // Addresses n*(IN+1)+k are contiguous across neurons.
          w_addr <= w_addr + WA_W'(1);
          if (k == KW'(IN)) state <= S_DRAIN;
          else              k     <= k + KW'(1);
        end
        S_DRAIN: state <= S_ACT;
        S_ACT: begin
          out      <= rq_q;
          udf      <= rq_udf;
          ovf      <= rq_ovf;
          rounded  <= rq_rnd;
          out_idx  <= n;
          out_last <= last_nrn;
          state    <= S_EMIT;
        end
        S_EMIT: begin
          if (out_ready) begin
            if (!last_nrn) begin
              n     <= n + NW'(1);
              k     <= '0;
              state <= S_FETCH;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/slp_seq_infer.md
Name: slp_seq_infer

Overview:
Sequential, multi-neuron successor to the combinational single-layer perceptron inference block. One input vector is accepted per transaction and evaluated against OUT neurons. Each neuron uses one time-multiplexed MAC over IN weights plus a bias, fetched from an external weight memory with a 1-cycle read latency. Results stream out one neuron at a time with valid/ready back-pressure and udf/ovf/rounded flags, for use as a layer engine in the perceptron datapath.

Parameters:
IN, 4, inputs per neuron (≥1)
OUT, 2, neurons per layer (≥1)
I_CONF, dconf_t'{INT,1,8,0}, input format (dtype, sign, prec, frac)
W_CONF, dconf_t'{INT,1,8,0}, weight/bias format
O_CONF, dconf_t'{INT,1,8,0}, output format
ACT, ReLU, actf_t activation; ReLU = max(0,x); every other encoding = identity
ACC_W, I_PREC+W_PREC+$clog2(IN+1)+1, accumulator width (derived; not overridden)
WA_W, $clog2(OUT*(IN+1)), weight address width (derived)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset_  in  1  asynchronous, active-low reset
in_valid  in  1  input vector valid
in_ready  out  1  block can accept a vector (high only in IDLE)
in_data  in  IN*I_PREC  packed input vector; element i at [i*I_PREC +: I_PREC]
w_rd_en  out  1  weight read strobe
w_addr  out  WA_W  weight index = n*(IN+1)+k; k==IN selects the bias
w_rdata  in  W_PREC  weight data, valid exactly 1 cycle after w_rd_en
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
out_idx  out  $clog2(OUT)+1  neuron index n
out_last  out  1  n==OUT-1
out  out  O_PREC  quantised activation
udf  out  1  saturated at the output minimum
ovf  out  1  saturated at the output maximum
rounded  out  1  nonzero fraction bits were discarded

Behaviour:
- Reset (async, reset_=0): state IDLE; all outputs 0 except in_ready=1; accumulator, n and k are cleared. A reset mid-transaction abandons it; no output is produced.
- FSM: IDLE -> FETCH -> DRAIN -> ACT -> EMIT -> (FETCH for n+1 | IDLE).
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_data, set n=0, k=0, clear acc. in_data is ignored after capture.
- FETCH: w_rd_en=1, w_addr=n*(IN+1)+k, k increments each cycle for IN+1 cycles (k=0..IN). The last issue moves to DRAIN.
- Returned data: in_reg[k]*w_rdata is accumulated one cycle after issue. For the bias (k==IN), add w_rdata sign-extended (if W_SIGN) and shifted left by I_FRAC. Unsigned formats are zero-extended. Products carry I_FRAC+W_FRAC fraction bits.
- DRAIN: w_rd_en=0; absorb the last (bias) return.
- ACT: apply ACT to acc, then requantise and register out/flags.
  - S = I_FRAC+W_FRAC-O_FRAC.
  - S>0: arithmetic shift right (floor); rounded=1 if discarded bits are nonzero.
  - S<=0: shift left; rounded=0.
  - Saturate to the O_CONF range: ovf=1 if above max (out=max); udf=1 if below min (out=min, which is 0 for unsigned).
  - ovf and udf are mutually exclusive.
- EMIT: out_valid=1; out/out_idx/out_last/flags stay stable until out_ready. On handshake: if n<OUT-1, n++, k=0, clear acc, go to FETCH; else go to IDLE. While stalled, no weight reads are issued.
- Timing: handshake at cycle 0 -> neuron 0 out_valid at cycle IN+4. Each following neuron is IN+4 cycles after the previous handshake. No overlap between neurons.
- out_valid drops the cycle after the final handshake. in_ready rises in that same cycle.
- ACC_W guarantees no accumulator overflow.

Decomposition:
- perceptron.svh package: dtype_t, dconf_t, actf_t; a new sat/round helper function shared with slp_infer; state enum slp_seq_state_t.
- One sub-module: slp_requant (combinational activation + shift + round + saturate), reused by other layer engines.

Test Plan:
- INT8, IN=4, OUT=2. Inputs 1,-2,-3,4. Neuron0 weights 1,1,1,1, bias 5 -> out=5, no flags, at cycle 8. Neuron1 weights 2,-1,0,1, bias -20 -> sum -12, ReLU -> out=0, out_last=1, at cycle 16.
- Overflow: inputs 100,100,0,0; weights 2,0,0,0; bias 0 -> sum 200 -> out=127, ovf=1. Same case with ACT=identity and weight -2 -> out=-128, udf=1.
- FXP: I_CONF{FXP,1,8,3}, W_CONF{FXP,1,16,4}, O_CONF{FXP,1,8,3}. in0=1.0 (8), w0=1.0625 (17), rest 0 -> out=8 (1.0), rounded=1.
- Back-pressure: hold out_ready=0 for 5 cycles in EMIT -> out_valid and fields stable, w_rd_en=0, in_ready=0. Release -> next neuron follows with normal timing.
- Reset mid-FETCH (k=2): reset_ low for 1 cycle -> all outputs 0 and in_ready=1 immediately. A new vector after release produces correct results.
- Address sequence check: OUT=3, IN=2 -> w_addr issues 0,1,2 | 3,4,5 | 6,7,8, each group contiguous, and in_data changes after capture do not affect results.
